// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types/constants for the instruction-memory loader.
//            Optional checksum stage enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BIDX_W         = 2;
    localparam logic [BIDX_W-1:0] LAST_BIDX = 2'(BYTES_PER_WORD - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
// ============================================================================
// Module   : byte_assembler
// Purpose  : Packs a little-endian byte stream into 32-bit words and flags
//            each completed word with a one-cycle word_valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BIDX_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;

    // Bytes enter at the top, so after four shifts byte0 sits in [7:0].
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (accept) begin
            word_d  = {in_data, word_q[WORD_W-1:8]};
            idx_d   = idx_q + 2'd1;
            valid_d = (idx_q == LAST_BIDX);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a length-prefixed program byte stream into instruction
//            memory, holding the CPU until done. IMEM_LOADER_CHECKSUM_EN adds
//            a trailing sum-check word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] n_q, n_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic              w_accept;
    logic              w_clear;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
`endif

    assign w_accept = in_valid & in_ready;

    byte_assembler u_byte_assembler (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (w_clear),
        .accept     (w_accept),
        .in_data    (in_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        w_clear = 1'b0;
        imem_we = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A fresh load must not inherit stray bytes from the last one.
                if (start) begin
                    state_d = S_COUNT;
                    w_clear = 1'b1;
                    n_d     = '0;
                    cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_COUNT: begin
                if (w_word_valid) begin
                    n_d = w_word;
                    if (w_word == '0 || w_word > WORD_W'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (w_word_valid) begin
                    imem_we = 1'b1;
                    cnt_d   = cnt_q + WORD_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + w_word;
                    if (cnt_q == n_q - WORD_W'(1)) state_d = S_CHECK;
`else
                    if (cnt_q == n_q - WORD_W'(1)) state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_word_valid) begin
                    state_d = (w_word == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
`else
    assign in_ready = (state_q == S_COUNT) || (state_q == S_DATA);
`endif

    assign imem_addr  = AW'(cnt_q);
    assign imem_wdata = w_word;
    assign cpu_hold   = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them: clock and reset_n.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of instruction memory words.
REQ-003 The block SHALL have parameter AW, default 32, meaning the width of imem_addr.
REQ-004 Port clock, input, 1 bit: rising-edge clock for all state.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle pulse that begins a load.
REQ-007 Port in_valid, input, 1 bit: in_data holds a valid byte.
REQ-008 Port in_data, input, 8 bits: program byte stream, little-endian within each word.
REQ-009 Port in_ready, output, 1 bit: the block can accept a byte.
REQ-010 Port imem_we, output, 1 bit: write strobe to instruction memory.
REQ-011 Port imem_addr, output, AW bits: word address of the write.
REQ-012 Port imem_wdata, output, 32 bits: instruction word to write.
REQ-013 Port cpu_hold, output, 1 bit: holds the PC and pipeline while high.
REQ-014 Port done, output, 1 bit: the load completed successfully (sticky).
REQ-015 Port error, output, 1 bit: the load was aborted (sticky).

Function
REQ-016 A byte SHALL transfer only on a rising edge where in_valid and in_ready are both 1.
REQ-017 The block SHALL have the FSM states IDLE, COUNT, DATA, CHECK, DONE and ERR.
- IDLE -> COUNT on start.
- DONE or ERR -> COUNT on start; done and error clear in that cycle.
- start is ignored in COUNT, DATA and CHECK.
REQ-018 in_ready SHALL be 1 only in COUNT, DATA and CHECK; bytes offered in any other state SHALL be ignored.
REQ-019 A 2-bit byte index SHALL assemble each word as byte0 into [7:0] through byte3 into [31:24], and the index SHALL wrap from 3 to 0.
REQ-020 In COUNT, the first assembled word SHALL be taken as N, the number of words to load.
- N = 0 or N > DEPTH -> ERR.
- Otherwise -> DATA, with the word counter set to 0.
REQ-021 In DATA, each completed word k SHALL produce imem_we = 1 for exactly one cycle, on the cycle after its 4th byte is accepted, with imem_addr = k and imem_wdata = the word.
REQ-022 The write of the last word (k = N-1) SHALL move the FSM to DONE, or to CHECK when CHECK is compiled in.
REQ-023 Consecutive words SHALL load at full rate with no bubbles; in_valid may stay high continuously.
REQ-024 cpu_hold SHALL be 1 in every state except DONE, so the CPU runs only after a successful load.
REQ-025 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR.
REQ-026 Stalls (in_valid = 0 mid-word) SHALL hold the partial word and the byte index unchanged.

Reset
REQ-027 On reset_n = 0, the block SHALL asynchronously force the state to IDLE, the byte index to 0, the word counter to 0 and the partial word to 0.
REQ-028 In reset, the outputs SHALL be in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_hold = 1, done = 0 and error = 0.
REQ-029 A reset during a load SHALL discard the partial word and raise no imem_we after reset is released.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: after the N data words, the block SHALL accept one more 4-byte word in CHECK.
- The check value is the modulo-2^32 sum of the N data words.
- Check value equal -> DONE; unequal -> ERR.
- The checksum word SHALL NOT be written to memory.
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN undefined: the CHECK state, the accumulator and the comparison logic SHALL be absent, and the last data word SHALL lead directly to DONE.

Structure
REQ-032 A shared package imem_loader_pkg SHALL hold the state encoding, BYTES_PER_WORD = 4 and the word width of 32.
REQ-033 Sub-module byte_assembler SHALL contain the byte shift register and the byte index, and SHALL emit a one-cycle word_valid; the FSM and counters SHALL stay in imem_loader.

Verification
REQ-034 Basic load: start, then bytes 02 00 00 00, 78 56 34 12, EF CD AB 89 -> imem_we at addr 0 with 0x12345678, then at addr 1 with 0x89ABCDEF; done = 1 and cpu_hold = 0 after the last write.
REQ-035 Zero count: count word 0x00000000 -> error = 1, no imem_we, and cpu_hold stays 1.
REQ-036 Oversize count: count 257 with DEPTH = 256 -> error = 1 and no imem_we.
REQ-037 Stalls and reset:
- Stalls: in_valid toggling 1,0,0,1 mid-word -> same words and addresses as REQ-034.
- Reset: assert reset_n after 2 data bytes -> IDLE; a new start and stream load correctly from addr 0.
REQ-038 With IMEM_LOADER_CHECKSUM_EN defined, the REQ-034 words followed by the checksum:
- Checksum 0x9BE02467 -> done = 1.
- Checksum 0x9BE02468 -> error = 1, with both data words already written.
REQ-039 Restart: a start pulse in DONE -> done clears, cpu_hold = 1, and a second program overwrites from addr 0.
